vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator for the display path; replaces the fixed 1024x768 generator. Produces h/v sync with configurable polarity, active-video flag, raster coordinates, line/frame strobes, and optionally a lead-ahead fetch coordinate for the frame-buffer read pipeline. Sits between the pixel clock domain root and the video address generator / DAC output stage.

## Interface
- H_VIS, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 144, horizontal back porch (pixels)
- V_VIS, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- H_POL, 0, active level of h_sync (0 = active-low)
- V_POL, 0, active level of v_sync
- CW, 12, coordinate counter width
- FETCH_LEAD, 4, fetch lead in pixels (PREFETCH build only), 1..H_VIS-1
- clk  in  1  pixel-domain clock
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel advance enable; counters move only on clk edges with pix_ce=1
- h_sync  out  1  horizontal sync, level per H_POL
- v_sync  out  1  vertical sync, level per V_POL
- avr  out  1  active video region (h and v both visible)
- vblank  out  1  line_y >= V_VIS
- pixel_x  out  CW  raw horizontal count, 0..H_TOTAL-1
- line_y  out  CW  raw vertical count, 0..V_TOTAL-1
- line_start  out  1  one-clk strobe, pixel_x just became 0
- frame_start  out  1  one-clk strobe, position just became (0,0)
- fetch_x, fetch_y  out  CW each  coordinate displayed FETCH_LEAD pix_ce ticks later (PREFETCH)
- fetch_valid  out  1  (fetch_x, fetch_y) lies in visible region (PREFETCH)

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Order within each axis: VIS, FP, SYNC, BP.
- Per-axis state from count c: VIS c<VIS; FP c<VIS+FP; SYNC c<VIS+FP+SYNC; else BP.
- On pix_ce: h_cnt wraps H_TOTAL-1 -> 0, else +1. On that wrap v_cnt wraps V_TOTAL-1 -> 0, else +1. Both wrap simultaneously at end of frame.
- All outputs are registers updated on the same edge as the counters and describe the new position; zero skew between coordinates, syncs and avr.
- h_sync = H_POL when h in SYNC else ~H_POL; v_sync same on v axis (v_sync spans whole lines).
- pixel_x/line_y continue counting through blanking (values >= H_VIS / V_VIS).
- Strobes are high only in the clk cycle after the advancing edge; low on cycles where pix_ce=0 held.
- Elaboration error if any porch/sync is 0, H_TOTAL or V_TOTAL > 2**CW, or FETCH_LEAD out of range.

## Timing
- Reset (async assert): counters = (H_TOTAL-1, V_TOTAL-1); avr=0, vblank=1, h_sync=~H_POL, v_sync=~V_POL, pixel_x=line_y=0, strobes 0, fetch_valid=0, fetch_x/y=0.
- Reset release: first pix_ce edge -> position (0,0), avr=1, vblank=0, line_start=frame_start=1.
- Latency pix_ce edge -> outputs: 0 extra cycles (registered at that edge).
- Reset asserted mid-frame: immediate return to reset values; no partial sync pulse continues.
- pix_ce=0: all outputs hold except strobes.
- Fetch counter: independent counter pair running FETCH_LEAD ticks ahead, wrapping across line and frame; after reset initialised to FETCH_LEAD-1 ticks before (0,0)'s fetch, so fetch_x = (pixel_x+FETCH_LEAD) mod H_TOTAL with line carry.

## Configuration
- VGA_TIMING_PREFETCH_EN defined: fetch_x, fetch_y, fetch_valid and fetch counter pair present.
- Undefined: those ports absent, FETCH_LEAD ignored, no fetch logic.

## Structure
- Package vga_timing_pkg: axis state enum (VIS, FP, SYNC, BP); preset constant sets for 1024x768@70 (75 MHz) and 1368x768 (H 1368/72/144/216, V 768/1/3/23).
- Sub-module vga_axis_counter (count, wrap, state decode, sync level), instantiated for h and v, and twice more for fetch when enabled.

## Test plan
- Reset released, pix_ce=1 constant, defaults -> h_sync low for 136 clocks starting pixel_x=1048; line period 1328 clocks; frame 806 lines = 1070368 clocks between frame_start pulses.
- Count avr-high cycles over one frame -> exactly 1024*768 = 786432; v_sync low lines 771..776.
- pix_ce toggling 1-of-3 -> all periods scale x3; line_start width exactly 1 clk.
- H_POL=1, V_POL=1, 1368x768 preset -> h_sync high at pixel_x 1440..1583, H_TOTAL 1800, V_TOTAL 795.
- rst_n pulsed low at pixel_x=1100 during sync -> h_sync returns to ~H_POL asynchronously; restart at (0,0) on next pix_ce.
- PREFETCH, FETCH_LEAD=4 -> at pixel_x=1326, fetch=(2, line_y+1), fetch_valid=1; at position (1327,805) fetch=(3,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared axis-state type, timing presets and axis decode for the VGA raster timing generator.
package vga_timing_pkg;

   typedef enum logic [1:0] {AX_VIS, AX_FP, AX_SYNC, AX_BP} axis_state_e;

   typedef struct packed {
      int h_vis;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_vis;
      int v_fp;
      int v_sync;
      int v_bp;
   } timing_preset_t;

   // 1024x768 @ 70 Hz, 75 MHz pixel clock
   localparam timing_preset_t PRESET_1024X768_70 = '{
      h_vis: 1024, h_fp: 24, h_sync: 136, h_bp: 144,
      v_vis: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29
   };
   localparam int PRESET_1024X768_70_PCLK_KHZ = 75000;

   localparam timing_preset_t PRESET_1368X768 = '{
      h_vis: 1368, h_fp: 72, h_sync: 144, h_bp: 216,
      v_vis: 768,  v_fp: 1,  v_sync: 3,   v_bp: 23
   };

   function automatic axis_state_e axis_state(input int c, input int vis, input int fp,
                                              input int sync_w);
      if (c < vis)                    return AX_VIS;
      else if (c < vis + fp)          return AX_FP;
      else if (c < vis + fp + sync_w) return AX_SYNC;
      else                            return AX_BP;
   endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping counter, next-position state decode and registered sync level.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VIS     = 1024,
   parameter int FP      = 24,
   parameter int SYNC    = 136,
   parameter int BP      = 144,
   parameter bit POL     = 1'b0,
   parameter int CW      = 12,
   parameter int RST_VAL = VIS + FP + SYNC + BP - 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          adv,
   output logic          at_last,
   output logic [CW-1:0] cnt_nxt,
   output axis_state_e   state_nxt,
   output logic          sync
);

   localparam int TOTAL = VIS + FP + SYNC + BP;
   localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

   logic [CW-1:0] cnt;

   always_comb begin
      at_last   = (cnt == LAST);
      cnt_nxt   = at_last ? '0 : cnt + CW'(1);
      state_nxt = axis_state(int'(cnt_nxt), VIS, FP, SYNC);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= CW'(RST_VAL);
         sync <= ~POL;
      end else if (adv) begin
         cnt  <= cnt_nxt;
         sync <= (state_nxt == AX_SYNC) ? POL : ~POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; all outputs registered on the advancing edge.
// Optional lead-ahead fetch coordinate enabled by VGA_TIMING_PREFETCH_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VIS      = PRESET_1024X768_70.h_vis,
   parameter int H_FP       = PRESET_1024X768_70.h_fp,
   parameter int H_SYNC     = PRESET_1024X768_70.h_sync,
   parameter int H_BP       = PRESET_1024X768_70.h_bp,
   parameter int V_VIS      = PRESET_1024X768_70.v_vis,
   parameter int V_FP       = PRESET_1024X768_70.v_fp,
   parameter int V_SYNC     = PRESET_1024X768_70.v_sync,
   parameter int V_BP       = PRESET_1024X768_70.v_bp,
   parameter bit H_POL      = 1'b0,
   parameter bit V_POL      = 1'b0,
   parameter int CW         = 12,
   parameter int FETCH_LEAD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_ce,
   output logic          h_sync,
   output logic          v_sync,
   output logic          avr,
   output logic          vblank,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] line_y,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_TIMING_PREFETCH_EN
   ,
   output logic [CW-1:0] fetch_x,
   output logic [CW-1:0] fetch_y,
   output logic          fetch_valid
`endif
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   generate
      if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_porch
         $error("vga_timing_gen: porch and sync widths must be non-zero");
      end
      if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_err_width
         $error("vga_timing_gen: raster totals exceed coordinate width CW");
      end
   endgenerate

   logic          h_last, v_last, v_vis_new;
   logic [CW-1:0] h_nxt, v_nxt;
   axis_state_e   h_st, v_st;

   vga_axis_counter #(
      .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CW(CW)
   ) u_h_axis (
      .clk(clk), .rst_n(rst_n), .adv(pix_ce),
      .at_last(h_last), .cnt_nxt(h_nxt), .state_nxt(h_st), .sync(h_sync)
   );

   vga_axis_counter #(
      .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CW(CW)
   ) u_v_axis (
      .clk(clk), .rst_n(rst_n), .adv(pix_ce & h_last),
      .at_last(v_last), .cnt_nxt(v_nxt), .state_nxt(v_st), .sync(v_sync)
   );

   // Line visibility only changes on a horizontal wrap; otherwise it follows the held line.
   always_comb begin
      v_vis_new = h_last ? (v_st == AX_VIS) : ~vblank;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_x     <= '0;
         line_y      <= '0;
         avr         <= 1'b0;
         vblank      <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_ce & h_last;
         frame_start <= pix_ce & h_last & v_last;
         if (pix_ce) begin
            pixel_x <= h_nxt;
            avr     <= (h_st == AX_VIS) && v_vis_new;
            if (h_last) begin
               line_y <= v_nxt;
               vblank <= (v_st != AX_VIS);
            end
         end
      end
   end

`ifdef VGA_TIMING_PREFETCH_EN
   generate
      if (FETCH_LEAD < 1 || FETCH_LEAD > H_VIS - 1) begin : g_err_lead
         $error("vga_timing_gen: FETCH_LEAD must be in 1..H_VIS-1");
      end
   endgenerate

   logic          fh_last, fv_last, fh_sync, fv_sync, fy_vis;
   logic [CW-1:0] fh_nxt, fv_nxt;
   axis_state_e   fh_st, fv_st;
   logic          fetch_unused;

   // Starts FETCH_LEAD-1 ticks into line 0 so the first advance lands FETCH_LEAD ahead of (0,0).
   vga_axis_counter #(
      .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CW(CW),
      .RST_VAL(FETCH_LEAD - 1)
   ) u_fh_axis (
      .clk(clk), .rst_n(rst_n), .adv(pix_ce),
      .at_last(fh_last), .cnt_nxt(fh_nxt), .state_nxt(fh_st), .sync(fh_sync)
   );

   vga_axis_counter #(
      .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CW(CW),
      .RST_VAL(0)
   ) u_fv_axis (
      .clk(clk), .rst_n(rst_n), .adv(pix_ce & fh_last),
      .at_last(fv_last), .cnt_nxt(fv_nxt), .state_nxt(fv_st), .sync(fv_sync)
   );

   assign fetch_unused = ^{fv_last, fh_sync, fv_sync};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_x     <= '0;
         fetch_y     <= '0;
         fetch_valid <= 1'b0;
         fy_vis      <= 1'b1;
      end else if (pix_ce) begin
         fetch_x     <= fh_nxt;
         fetch_valid <= (fh_st == AX_VIS) && (fh_last ? (fv_st == AX_VIS) : fy_vis);
         if (fh_last) begin
            fetch_y <= fv_nxt;
            fy_vis  <= (fv_st == AX_VIS);
         end
      end
   end
`else
   localparam int unused_fetch_lead = FETCH_LEAD;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default, 1368x768 and a small randomized raster.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   int total = 0;
   int bad   = 0;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic pix_ce = 1'b0;
   always #5 clk = ~clk;

   localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2, SHT = 15;
   localparam int SVV = 5, SVF = 1, SVS = 2, SVB = 1, SVT = 9;
   localparam int SLEAD = 6;

   logic a_hs, a_vs, a_avr, a_vb, a_ls, a_fs;
   logic b_hs, b_vs, b_avr, b_vb, b_ls, b_fs;
   logic c_hs, c_vs, c_avr, c_vb, c_ls, c_fs;
   logic [11:0] a_x, a_y, b_x, b_y;
   logic [4:0]  c_x, c_y;
`ifdef VGA_TIMING_PREFETCH_EN
   logic [11:0] a_fx, a_fy, b_fx, b_fy;
   logic [4:0]  c_fx, c_fy;
   logic        a_fv, b_fv, c_fv;
`endif

   vga_timing_gen dut_a (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .h_sync(a_hs), .v_sync(a_vs),
      .avr(a_avr), .vblank(a_vb), .pixel_x(a_x), .line_y(a_y),
      .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv)
`endif
   );

   vga_timing_gen #(
      .H_VIS(PRESET_1368X768.h_vis), .H_FP(PRESET_1368X768.h_fp),
      .H_SYNC(PRESET_1368X768.h_sync), .H_BP(PRESET_1368X768.h_bp),
      .V_VIS(PRESET_1368X768.v_vis), .V_FP(PRESET_1368X768.v_fp),
      .V_SYNC(PRESET_1368X768.v_sync), .V_BP(PRESET_1368X768.v_bp),
      .H_POL(1'b1), .V_POL(1'b1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .h_sync(b_hs), .v_sync(b_vs),
      .avr(b_avr), .vblank(b_vb), .pixel_x(b_x), .line_y(b_y),
      .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .fetch_x(b_fx), .fetch_y(b_fy), .fetch_valid(b_fv)
`endif
   );

   vga_timing_gen #(
      .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .H_POL(1'b1), .V_POL(1'b0), .CW(5), .FETCH_LEAD(SLEAD)
   ) dut_c (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .h_sync(c_hs), .v_sync(c_vs),
      .avr(c_avr), .vblank(c_vb), .pixel_x(c_x), .line_y(c_y),
      .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .fetch_x(c_fx), .fetch_y(c_fy), .fetch_valid(c_fv)
`endif
   );

   task automatic tick(input logic ce);
      pix_ce = ce;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pix_ce = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if ({a_hs, a_vs, a_avr, a_vb, a_ls, a_fs} !== 6'b110100) begin bad++;
         $display("FAIL reset_flags_a got=%b want=110100", {a_hs, a_vs, a_avr, a_vb, a_ls, a_fs}); end
      total++; if ({a_x, a_y} !== 24'd0) begin bad++;
         $display("FAIL reset_coords_a got=%0d,%0d want=0,0", a_x, a_y); end
      total++; if ({b_hs, b_vs} !== 2'b00) begin bad++;
         $display("FAIL reset_sync_pol1 got=%b want=00", {b_hs, b_vs}); end
`ifdef VGA_TIMING_PREFETCH_EN
      total++; if ({a_fx, a_fy, a_fv} !== 25'd0) begin bad++;
         $display("FAIL reset_fetch got=%0d,%0d,%b want=0,0,0", a_fx, a_fy, a_fv); end
`endif
      rst_n = 1'b1;
      tick(1'b0);
      total++; if ({a_x, a_avr, a_ls, a_fs, a_vb} !== {12'd0, 4'b0001}) begin bad++;
         $display("FAIL hold_before_first got=%0d,%b want=0,0001", a_x, {a_avr, a_ls, a_fs, a_vb}); end
      tick(1'b1);
      total++; if ({a_x, a_y, a_avr, a_vb, a_ls, a_fs} !== {24'd0, 4'b1011}) begin bad++;
         $display("FAIL first_advance got=%0d,%0d,%b want=0,0,1011", a_x, a_y, {a_avr, a_vb, a_ls, a_fs}); end
`ifdef VGA_TIMING_PREFETCH_EN
      total++; if ({a_fx, a_fy, a_fv} !== {12'd4, 12'd0, 1'b1}) begin bad++;
         $display("FAIL first_fetch got=%0d,%0d,%b want=4,0,1", a_fx, a_fy, a_fv); end
`endif
      tick(1'b0);
      total++; if ({a_x, a_avr, a_ls, a_fs} !== {12'd0, 3'b100}) begin bad++;
         $display("FAIL strobe_drop_ce0 got=%0d,%b want=0,100", a_x, {a_avr, a_ls, a_fs}); end
      tick(1'b1);
      total++; if ({a_x, a_ls} !== {12'd1, 1'b0}) begin bad++;
         $display("FAIL second_advance got=%0d,%b want=1,0", a_x, a_ls); end
   endtask

   task automatic test_line_default();
      int x, y, low_cnt, first_low, last_ls, n_ls;
      logic [27:0] got, exp;
      do_reset();
      rst_n = 1'b1;
      low_cnt = 0; first_low = -1; last_ls = -1; n_ls = 0;
      for (int k = 0; k < 2 * 1328 + 6; k++) begin
         tick(1'b1);
         x = k % 1328;
         y = k / 1328;
         got = {a_x, a_y, a_hs, a_ls, a_avr, a_vb};
         exp = {12'(x), 12'(y), !(x >= 1048 && x < 1184), x == 0, (x < 1024 && y < 768), 1'b0};
         total++; if (got !== exp) begin bad++;
            $display("FAIL line_default k=%0d got=%h want=%h", k, got, exp); end
         if (k < 1328 && a_hs === 1'b0) begin
            if (first_low < 0) first_low = int'(a_x);
            low_cnt++;
         end
         if (a_ls === 1'b1) begin
            n_ls++;
            if (last_ls >= 0) begin
               total++; if (k - last_ls !== 1328) begin bad++;
                  $display("FAIL line_period got=%0d want=1328", k - last_ls); end
            end
            last_ls = k;
         end
      end
      total++; if (first_low !== 1048) begin bad++;
         $display("FAIL hsync_start got=%0d want=1048", first_low); end
      total++; if (low_cnt !== 136) begin bad++;
         $display("FAIL hsync_width got=%0d want=136", low_cnt); end
      total++; if (n_ls !== 3) begin bad++;
         $display("FAIL line_start_count got=%0d want=3", n_ls); end
   endtask

   task automatic test_ce_third();
      int n, x, last_ls, n_ls;
      logic ce, prev_ls;
      logic [12:0] got, exp;
      do_reset();
      rst_n = 1'b1;
      n = 0; last_ls = -1; n_ls = 0; prev_ls = 1'b0;
      for (int i = 0; i < 3 * 1328 * 2 + 12; i++) begin
         ce = (i % 3 == 0);
         tick(ce);
         if (ce) n++;
         x = (n - 1) % 1328;
         got = {a_x, a_ls};
         exp = {12'(x), ce && x == 0};
         total++; if (got !== exp) begin bad++;
            $display("FAIL ce_third i=%0d got=%h want=%h", i, got, exp); end
         if (a_ls === 1'b1) begin
            n_ls++;
            total++; if (prev_ls !== 1'b0) begin bad++;
               $display("FAIL ls_width i=%0d got=2 want=1", i); end
            if (last_ls >= 0) begin
               total++; if (i - last_ls !== 3984) begin bad++;
                  $display("FAIL ce_third_period got=%0d want=3984", i - last_ls); end
            end
            last_ls = i;
         end
         prev_ls = a_ls;
      end
      total++; if (n_ls !== 3) begin bad++;
         $display("FAIL ce_third_count got=%0d want=3", n_ls); end
   endtask

   task automatic test_preset_1368();
      int x, y, high_cnt, first_high, last_ls;
      logic [28:0] got, exp;
      do_reset();
      rst_n = 1'b1;
      high_cnt = 0; first_high = -1; last_ls = -1;
      for (int k = 0; k < 1800 + 6; k++) begin
         tick(1'b1);
         x = k % 1800;
         y = k / 1800;
         got = {b_x, b_y, b_hs, b_vs, b_ls, b_avr, b_vb};
         exp = {12'(x), 12'(y), (x >= 1440 && x < 1584), 1'b0, x == 0, (x < 1368), 1'b0};
         total++; if (got !== exp) begin bad++;
            $display("FAIL preset_1368 k=%0d got=%h want=%h", k, got, exp); end
         if (k < 1800 && b_hs === 1'b1) begin
            if (first_high < 0) first_high = int'(b_x);
            high_cnt++;
         end
         if (b_ls === 1'b1) begin
            if (last_ls >= 0) begin
               total++; if (k - last_ls !== 1800) begin bad++;
                  $display("FAIL h_total_1368 got=%0d want=1800", k - last_ls); end
            end
            last_ls = k;
         end
      end
      total++; if (first_high !== 1440) begin bad++;
         $display("FAIL hsync_start_1368 got=%0d want=1440", first_high); end
      total++; if (high_cnt !== 144) begin bad++;
         $display("FAIL hsync_width_1368 got=%0d want=144", high_cnt); end
   endtask

   task automatic test_reset_mid_sync();
      int cyc;
      do_reset();
      rst_n = 1'b1;
      cyc = 0;
      while (a_x !== 12'd1100 && cyc < 2000) begin
         tick(1'b1);
         cyc++;
      end
      total++; if (a_x !== 12'd1100) begin bad++;
         $display("FAIL reach_1100 got=%0d want=1100", a_x); end
      total++; if (a_hs !== 1'b0) begin bad++;
         $display("FAIL hs_in_sync got=%b want=0", a_hs); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({a_hs, a_vs, a_avr, a_vb, a_x, a_y} !== {4'b1101, 24'd0}) begin bad++;
         $display("FAIL async_reset got=%b,%0d,%0d want=1101,0,0", {a_hs, a_vs, a_avr, a_vb}, a_x, a_y); end
      tick(1'b1);
      tick(1'b1);
      total++; if ({a_hs, a_avr, a_ls, a_x} !== {3'b100, 12'd0}) begin bad++;
         $display("FAIL reset_held got=%b,%0d want=100,0", {a_hs, a_avr, a_ls}, a_x); end
      rst_n = 1'b1;
      tick(1'b1);
      total++; if ({a_x, a_y, a_ls, a_fs, a_avr, a_hs} !== {24'd0, 4'b1111}) begin bad++;
         $display("FAIL restart got=%0d,%0d,%b want=0,0,1111", a_x, a_y, {a_ls, a_fs, a_avr, a_hs}); end
   endtask

`ifdef VGA_TIMING_PREFETCH_EN
   task automatic test_fetch_default();
      int cyc;
      do_reset();
      rst_n = 1'b1;
      cyc = 0;
      while (a_x !== 12'd1326 && cyc < 2000) begin
         tick(1'b1);
         cyc++;
         if (a_x === 12'd1020) begin
            total++; if ({a_fx, a_fv} !== {12'd1024, 1'b0}) begin bad++;
               $display("FAIL fetch_edge got=%0d,%b want=1024,0", a_fx, a_fv); end
         end
      end
      total++; if ({a_x, a_y, a_fx, a_fy, a_fv} !== {12'd1326, 12'd0, 12'd2, 12'd1, 1'b1}) begin bad++;
         $display("FAIL fetch_1326 got=%0d,%0d,%0d,%0d,%b want=1326,0,2,1,1", a_x, a_y, a_fx, a_fy, a_fv); end
      tick(1'b1);
      total++; if ({a_fx, a_fy, a_fv} !== {12'd3, 12'd1, 1'b1}) begin bad++;
         $display("FAIL fetch_1327 got=%0d,%0d,%b want=3,1,1", a_fx, a_fy, a_fv); end
   endtask
`endif

   task automatic test_random_small();
      int n, p, f, ex, ey, efx, efy, avr_cnt, frames;
      logic ce, in_frame, ehs, evs, eavr, evb, els, efs, efv;
      logic [15:0] got, exp;
      do_reset();
      rst_n = 1'b1;
      n = 0; avr_cnt = 0; frames = 0; in_frame = 1'b0;
      for (int i = 0; i < 1600; i++) begin
         if (i == 700) begin
            repeat ($urandom_range(1, 40)) tick(1'b1);
            do_reset();
            rst_n = 1'b1;
            n = 0; avr_cnt = 0; in_frame = 1'b0;
         end
         ce = ($urandom_range(0, 3) != 0);
         tick(ce);
         if (ce) n++;
         if (n == 0) begin
            ex = 0; ey = 0; ehs = 1'b0; evs = 1'b1; eavr = 1'b0; evb = 1'b1;
            els = 1'b0; efs = 1'b0; efx = 0; efy = 0; efv = 1'b0;
         end else begin
            p    = n - 1;
            ex   = p % SHT;
            ey   = (p / SHT) % SVT;
            ehs  = (ex >= SHV + SHF && ex < SHV + SHF + SHS);
            evs  = !(ey >= SVV + SVF && ey < SVV + SVF + SVS);
            eavr = (ex < SHV && ey < SVV);
            evb  = (ey >= SVV);
            els  = ce && ex == 0;
            efs  = els && ey == 0;
            f    = p + SLEAD;
            efx  = f % SHT;
            efy  = (f / SHT) % SVT;
            efv  = (efx < SHV && efy < SVV);
         end
         got = {c_x, c_y, c_hs, c_vs, c_avr, c_vb, c_ls, c_fs};
         exp = {5'(ex), 5'(ey), ehs, evs, eavr, evb, els, efs};
         total++; if (got !== exp) begin bad++;
            $display("FAIL random_small i=%0d n=%0d got=%h want=%h", i, n, got, exp); end
`ifdef VGA_TIMING_PREFETCH_EN
         total++; if ({c_fx, c_fy, c_fv} !== {5'(efx), 5'(efy), efv}) begin bad++;
            $display("FAIL random_fetch i=%0d got=%0d,%0d,%b want=%0d,%0d,%b", i, c_fx, c_fy, c_fv, efx, efy, efv); end
`endif
         if (ce && c_fs === 1'b1) begin
            if (in_frame) begin
               frames++;
               total++; if (avr_cnt !== SHV * SVV) begin bad++;
                  $display("FAIL avr_per_frame got=%0d want=%0d", avr_cnt, SHV * SVV); end
            end
            in_frame = 1'b1;
            avr_cnt = 0;
         end
         if (ce && c_avr === 1'b1) avr_cnt++;
      end
      total++; if (frames < 4) begin bad++;
         $display("FAIL frames_seen got=%0d want>=4", frames); end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_line_default();
      test_ce_third();
      test_preset_1368();
      test_reset_mid_sync();
`ifdef VGA_TIMING_PREFETCH_EN
      test_fetch_default();
`endif
      test_random_small();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
